// File: rtl/matrix_loader.sv
// Streams row-major matrix elements into a packed NxN buffer.
// Holds the finished matrix with matrix_valid until the next start.
module matrix_loader #(
  parameter int N = 5,
  parameter int W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       size,
  input  logic             in_valid,
  input  logic [W-1:0]     in_data,
  output logic             in_ready,
  output logic [N*N*W-1:0] matrix_a,
  output logic             matrix_valid,
  output logic             busy,
  output logic [4:0]       load_count
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } state_t;

  state_t     state;
  logic [2:0] row;
  logic [2:0] col;
  logic [2:0] dim;
  logic [2:0] last;
  logic [2:0] size_c;
  logic       accept;
  logic       last_beat;

  // Out-of-range sizes fall back to the full matrix
  assign size_c = (size == 3'd0 || size > 3'(N)) ? 3'(N) : size;
  assign last = dim - 3'd1;
  assign accept = (state == LOAD) && in_valid;
  assign last_beat = (row == last) && (col == last);

  assign in_ready = (state == LOAD);
  assign busy = (state == LOAD);
  assign matrix_valid = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      matrix_a <= '0;
      row <= '0;
      col <= '0;
      dim <= 3'(N);
      load_count <= '0;
    end else if (start) begin
      state <= LOAD;
      matrix_a <= '0;
      row <= '0;
      col <= '0;
      dim <= size_c;
      load_count <= '0;
    end else if (accept) begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          if (i == int'(row) && j == int'(col)) begin
            matrix_a[i*N*W + j*W +: W] <= in_data;
          end
        end
      end
      load_count <= load_count + 5'd1;
      if (col == last) begin
        col <= '0;
        row <= row + 3'd1;
      end else begin
        col <= col + 3'd1;
      end
      if (last_beat) begin
        state <= DONE;
      end
    end
  end

endmodule

// File: doc/matrix_loader.md
# matrix_loader

Write-side feeder for the 5x5 matrix datapath. Accepts matrix elements one per beat over a valid/ready stream in row-major order and assembles them into the packed 200-bit `matrix_a` vector that the determinant and arithmetic blocks consume. Supports active dimensions 1..5; unused positions are zero. Signals completion with a level `matrix_valid` that holds until the next load starts.

## Interface
- `N`, 5: maximum matrix dimension (fixed at 5; packed width N*N*W = 200).
- `W`, 8: element width in bits.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  one-cycle request to begin a new load; accepted in any state.
- `size`  in  3  active dimension, sampled only on `start`; 1..5 valid, 0 or 6..7 clamp to 5.
- `in_valid`  in  1  element beat valid.
- `in_data`  in  8  element value, unsigned.
- `in_ready`  out  1  loader accepts a beat this cycle.
- `matrix_a`  out  200  packed matrix; element [i][j] at bits i*40 + j*8 +: 8.
- `matrix_valid`  out  1  high while a complete matrix is held.
- `busy`  out  1  high while in LOAD.
- `load_count`  out  5  number of elements accepted in the current load (0..25).

## Operation
- States: IDLE, LOAD, DONE. Reset enters IDLE.
- IDLE: `in_ready`=0, `busy`=0, `matrix_valid`=0. `start` -> LOAD.
- On `start` (any state): `matrix_a` cleared to 0, row=col=0, `load_count`=0, size latched after clamping, state -> LOAD.
- LOAD: `in_ready`=1, `busy`=1. A beat is accepted when `in_valid` && `in_ready`. An accepted beat writes `in_data` to element [row][col]. col increments. At col==size-1, col wraps to 0 and row increments. `load_count` increments.
- Last beat: the beat accepted at row==size-1, col==size-1. State -> DONE.
- DONE: `in_ready`=0, `busy`=0, `matrix_valid`=1, and `matrix_a` stays stable. Remains here until `start`.
- Start has priority. If `start` and an accepted-looking beat coincide in LOAD, the beat is discarded and not written. `in_ready` is still 1 that cycle, so the source must treat the beat as dropped. Sources must not drive data in the start cycle.
- Start in DONE or mid-LOAD: same as above. The partial or previous matrix is cleared, and `matrix_valid` falls.
- Positions with row ≥ size or col ≥ size remain 0 for the whole load.
- `in_valid` outside LOAD is ignored. There is no error flag.
- `in_ready` is decoded from the state register only (no combinational path from `in_valid`).

## Timing
- Reset values: state IDLE, `matrix_a`=0, `matrix_valid`=0, `in_ready`=0, `busy`=0, `load_count`=0. Reset is asynchronous assert, and is released on a clock edge. Reset mid-load discards everything.
- Start sampled at edge S. LOAD is active from S+1. The first beat can be accepted at edge S+1.
- An element written at edge k is visible on `matrix_a` after edge k.
- Last beat accepted at edge L: `matrix_valid`=1 and `in_ready`=0 from L+1 onward. Minimum L = S + size².
- Stalls (`in_valid`=0) add cycles 1:1 and do not change state.
- `start` at edge T while in DONE: `matrix_valid`=0 and `matrix_a`=0 after T.

## Test plan
- Size 2, beats 3,5,2,7 back-to-back after start -> `matrix_a`[7:0]=3, [15:8]=5, [47:40]=2, [55:48]=7, all other bits 0. `matrix_valid` rises 4 cycles after the start edge. `load_count`=4.
- Size 5, beats 1..25 with `in_valid` toggled every other cycle -> element [i][j]=5i+j+1. `matrix_valid` rises only after the 25th accept (49 cycles). `in_ready` is 0 in DONE.
- Size 0 and size 7 -> both load 25 elements, same as size 5.
- Restart: size 3, 4 beats of 0xFF, then start with size 2 and beats 1,2,3,4 -> `matrix_a` equals the size-2 pattern with no 0xFF residue.
- Start coincident with `in_valid`=1 in LOAD -> that beat is not written and `load_count`=0 the next cycle. In DONE, start drops `matrix_valid` after one edge.
- `rst_n` pulled low mid-load at count 7 -> all outputs return to reset values immediately, asynchronously. After release, `in_ready` stays 0 until `start`.
